// File: rtl/uart_bcd_digit_loader.sv
// UART 8N1 receiver feeding the two-digit display path. ASCII digits shift
// into a tens/units BCD pair, 'C'/'c' clears both digits, and CR/LF are
// accepted silently. Every other correctly framed byte raises char_err.
`timescale 1ns/1ps
module uart_bcd_digit_loader #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] dig1_bits,
  output logic [3:0] dig0_bits,
  output logic       update,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       char_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RECOVER
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             rx_m_q;
  logic             rx_s_q;

  logic [3:0]       dig1_q;
  logic [3:0]       dig0_q;
  logic [7:0]       rx_byte_q;
  logic             rx_valid_q;
  logic             update_q;
  logic             frame_err_q;
  logic             char_err_q;

  logic [3:0]       dig1_d;
  logic [3:0]       dig0_d;
  logic             update_d;
  logic             char_err_d;

  // Two-flop synchronizer; resets to the idle-high line level so a reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end

  // Character decode of the fully assembled byte; only committed when the stop bit is good
  always_comb begin
    dig1_d     = dig1_q;
    dig0_d     = dig0_q;
    update_d   = 1'b0;
    char_err_d = 1'b0;
    if (shift_q >= 8'h30 && shift_q <= 8'h39) begin
      dig1_d   = dig0_q;
      dig0_d   = shift_q[3:0];
      update_d = 1'b1;
    end else if (shift_q == 8'h43 || shift_q == 8'h63) begin
      dig1_d   = 4'd0;
      dig0_d   = 4'd0;
      update_d = 1'b1;
    end else if (shift_q == 8'h0D || shift_q == 8'h0A) begin
      update_d = 1'b0;
    end else begin
      char_err_d = 1'b1;
    end
  end

  // Receive FSM with registered digit/byte outputs and single-cycle status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      dig1_q      <= '0;
      dig0_q      <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      update_q    <= 1'b0;
      frame_err_q <= 1'b0;
      char_err_q  <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      update_q    <= 1'b0;
      frame_err_q <= 1'b0;
      char_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          bit_cnt_q <= '0;
          if (!rx_s_q) state_q <= S_START;
        end
        S_START: begin
          // Re-check mid start bit so short low glitches are dropped silently
          if (bit_cnt_q == HALF_LAST) begin
            bit_cnt_q <= '0;
            idx_q     <= '0;
            state_q   <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            if (idx_q == IDX_LAST) state_q <= S_STOP;
            else                   idx_q   <= idx_q + 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            if (rx_s_q) begin
              rx_byte_q  <= shift_q;
              rx_valid_q <= 1'b1;
              dig1_q     <= dig1_d;
              dig0_q     <= dig0_d;
              update_q   <= update_d;
              char_err_q <= char_err_d;
              state_q    <= S_IDLE;
            end else begin
              // Bad stop bit: drop the byte and wait out any break condition
              frame_err_q <= 1'b1;
              state_q     <= S_RECOVER;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_RECOVER: begin
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dig1_bits = dig1_q;
  assign dig0_bits = dig0_q;
  assign update    = update_q;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign char_err  = char_err_q;

endmodule
